spi_sram_responder: RTL and testbench
=====================================

// Module: spi_sram_responder
// PURPOSE
// Synthesizable SPI-mode-0 serial SRAM responder: the memory end of the delay core's RAM link.
// Decodes READ/WRITE from sck_ram/css_ram/sdo_ram and serves bytes on sdi_ram.
// Backing store is an internal byte array. Used as the RAM model in delay_core benches
// and as an on-FPGA stand-in when the external SRAM is absent.
// PARAMETERS
// ADDR_W      16  internal address width; depth = 2**ADDR_W bytes
// ADDR_BYTES  3   address bytes on the wire (24-bit wire address; upper bits ignored)
// OP_READ     8'h03  read opcode
// OP_WRITE    8'h02  write opcode
// PORTS
// clk       in   1  system clock; all logic on rising edge
// nrst      in   1  asynchronous active-low reset
// sck_ram   in   1  SPI clock from the core; idles low (mode 0)
// css_ram   in   1  chip select from the core, active low
// sdo_ram   in   1  serial data from the core (core MOSI)
// sdi_ram   out  1  serial data to the core (core MISO)
// busy      out  1  high while css_ram is sampled low
// wr_pulse  out  1  one-clk pulse per byte committed to the array
// bad_op    out  1  one-clk pulse when a non-READ/WRITE opcode completes
// BEHAVIOUR
// - Reset: sdi_ram=0, busy=0, wr_pulse=0, bad_op=0, state=IDLE, counters 0.
//   Array contents are not cleared.
// - Sync: sck_ram, css_ram and sdo_ram each pass a 2-flop synchronizer.
//   Rise/fall edges are detected on the synced sck.
//   Pin-to-detect latency is 3 clk. sck high and low phases must be >=4 clk each.
// - Mode 0, MSB first. Input bits are sampled on sck rise; sdi_ram changes only on sck fall
//   (<=4 clk after the pin edge) or on deselect.
// - FSM:
//   IDLE -> CMD on synced css fall.
//   CMD: 8 bits -> opcode. READ/WRITE -> ADDR. Other opcode -> IGNORE, with bad_op pulse.
//   ADDR: 8*ADDR_BYTES bits, shifted MSB first; low ADDR_W bits kept as the pointer.
//     Then -> RD (READ) or WR (WRITE).
//   RD: array[ptr] is fetched on the last address rise. Bit7 drives sdi_ram on the next sck fall.
//     Remaining bits are driven on the following falls.
//     On the 8th data rise: ptr+1, next byte fetched, its bit7 driven on the next fall.
//   WR: bits shift in on rises. On the 8th rise: array[ptr]<=byte, wr_pulse=1 for 1 clk, ptr+1.
//   IGNORE: sdi_ram held 0 and no array access until deselect.
// - Pointer wraps modulo 2**ADDR_W (0xFFFF+1 -> 0x0000 at the default). Sequential streaming is unbounded.
// - Deselect (synced css rise) in any state -> IDLE next clk. sdi_ram=0, bit counters cleared.
//   A partially shifted write byte is discarded; completed bytes stay written.
// - sdi_ram is 0 in IDLE/CMD/ADDR/IGNORE; outside RD it is always 0.
// - sck edges while css is high are ignored.
// - css fall and sck rise in the same synced cycle: css is processed first, and the edge
//   counts as bit 0 of CMD.
// - Reset mid-transfer: immediate return to reset values. The transaction is lost;
//   a new css fall is required.
// - busy = synced ~css_ram.
// TESTING
// - Write 02 000010 A5, then read 03 000010 + 8 clocks -> sdi_ram shifts 1010_0101; 1 wr_pulse.
// - Write 02 00FFFE 11 22 33, then read 03 00FFFE x3 bytes -> 11 22 33. The third byte lands
//   at 0x0000 (wrap); 3 wr_pulses.
// - Opcode 9F, then 24 clocks -> bad_op pulses once. sdi_ram stays 0, no wr_pulse;
//   a later read at 0 still returns the prior value.
// - Write 02 000020 C3 + 5 bits, then css high -> a read of 0x20 returns C3 and 0x21 is unchanged;
//   exactly 1 wr_pulse.
// - nrst low during a read data phase -> sdi_ram=0, busy=0 within 1 clk. After release,
//   a fresh read of the same address returns the correct byte.
// - Minimum timing: sck at 4 clk high / 4 clk low for a 4-byte sequential read -> all bits correct
//   at each sck rise.

Source files
------------

// File: rtl/spi_sram_responder.sv
// SPI mode-0 serial SRAM responder: decodes READ/WRITE transactions from the core's RAM
// link and serves an internal byte array. All pins are resynchronised into clk.
module spi_sram_responder #(
   parameter int          ADDR_W     = 16,
   parameter int          ADDR_BYTES = 3,
   parameter logic [7:0]  OP_READ    = 8'h03,
   parameter logic [7:0]  OP_WRITE   = 8'h02
) (
   input  logic clk,
   input  logic nrst,
   input  logic sck_ram,
   input  logic css_ram,
   input  logic sdo_ram,
   output logic sdi_ram,
   output logic busy,
   output logic wr_pulse,
   output logic bad_op
);

   localparam int SH_W  = (ADDR_W > 8) ? ADDR_W : 8;
   localparam int CNT_W = $clog2(8 * ADDR_BYTES);
   localparam int DEPTH = 1 << ADDR_W;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_CMD    = 3'd1;
   localparam logic [2:0] ST_ADDR   = 3'd2;
   localparam logic [2:0] ST_RD     = 3'd3;
   localparam logic [2:0] ST_WR     = 3'd4;
   localparam logic [2:0] ST_IGNORE = 3'd5;

   localparam logic [CNT_W-1:0] CNT_BYTE_LAST = CNT_W'(7);
   localparam logic [CNT_W-1:0] CNT_ADDR_LAST = CNT_W'(8 * ADDR_BYTES - 1);

   // [0] first stage, [1] synchronised value, [2] previous synchronised value for edges
   logic [2:0]        sck_sync_q, sck_sync_d;
   logic [2:0]        css_sync_q, css_sync_d;
   logic [1:0]        sdo_sync_q, sdo_sync_d;

   logic [2:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              is_rd_q, is_rd_d;
   logic              sdi_q, sdi_d;
   logic              wr_pulse_q, wr_pulse_d;
   logic              bad_op_q, bad_op_d;

   logic [SH_W-2:0]   sh_q, sh_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [7:0]        rd_byte_q;
   logic [7:0]        mem [0:DEPTH-1];

   logic              sck_rise, sck_fall, css_rise, css_fall, sdo_bit;
   logic [SH_W-1:0]   sh_in;
   logic [2:0]        st_eff;
   logic              wr_en, fetch_en;

   assign sck_sync_d = {sck_sync_q[1:0], sck_ram};
   assign css_sync_d = {css_sync_q[1:0], css_ram};
   assign sdo_sync_d = {sdo_sync_q[0], sdo_ram};

   assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
   assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
   assign css_rise = css_sync_q[1] & ~css_sync_q[2];
   assign css_fall = ~css_sync_q[1] & css_sync_q[2];
   assign sdo_bit  = sdo_sync_q[1];
   assign sh_in    = {sh_q, sdo_bit};

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      is_rd_d    = is_rd_q;
      sdi_d      = sdi_q;
      sh_d       = sh_q;
      ptr_d      = ptr_q;
      wr_pulse_d = 1'b0;
      bad_op_d   = 1'b0;
      wr_en      = 1'b0;
      fetch_en   = 1'b0;
      st_eff     = state_q;

      if (css_rise) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         // A select that lands together with the first sck rise still counts that rise as bit 0
         if (state_q == ST_IDLE && css_fall) begin
            st_eff  = ST_CMD;
            state_d = ST_CMD;
         end

         if (sck_rise) begin
            case (st_eff)
               ST_CMD: begin
                  sh_d = sh_in[SH_W-2:0];
                  if (cnt_q == CNT_BYTE_LAST) begin
                     cnt_d = '0;
                     if (sh_in[7:0] == OP_READ || sh_in[7:0] == OP_WRITE) begin
                        state_d = ST_ADDR;
                        is_rd_d = (sh_in[7:0] == OP_READ);
                     end else begin
                        state_d  = ST_IGNORE;
                        bad_op_d = 1'b1;
                     end
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
               ST_ADDR: begin
                  sh_d = sh_in[SH_W-2:0];
                  if (cnt_q == CNT_ADDR_LAST) begin
                     cnt_d = '0;
                     ptr_d = sh_in[ADDR_W-1:0];
                     if (is_rd_q) begin
                        state_d  = ST_RD;
                        fetch_en = 1'b1;
                     end else begin
                        state_d = ST_WR;
                     end
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
               ST_RD: begin
                  if (cnt_q == CNT_BYTE_LAST) begin
                     cnt_d    = '0;
                     ptr_d    = ptr_q + ADDR_W'(1);
                     fetch_en = 1'b1;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
               ST_WR: begin
                  sh_d = sh_in[SH_W-2:0];
                  if (cnt_q == CNT_BYTE_LAST) begin
                     cnt_d      = '0;
                     wr_en      = 1'b1;
                     wr_pulse_d = 1'b1;
                     ptr_d      = ptr_q + ADDR_W'(1);
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
               default: ;
            endcase
         end

         // cnt_q equals the number of rises already taken in the current byte
         if (sck_fall && state_q == ST_RD) begin
            sdi_d = rd_byte_q[3'd7 - cnt_q[2:0]];
         end
      end

      if (state_d != ST_RD) begin
         sdi_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         sck_sync_q <= 3'b000;
         css_sync_q <= 3'b111;
         sdo_sync_q <= 2'b00;
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         is_rd_q    <= 1'b0;
         sdi_q      <= 1'b0;
         wr_pulse_q <= 1'b0;
         bad_op_q   <= 1'b0;
      end else begin
         sck_sync_q <= sck_sync_d;
         css_sync_q <= css_sync_d;
         sdo_sync_q <= sdo_sync_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         is_rd_q    <= is_rd_d;
         sdi_q      <= sdi_d;
         wr_pulse_q <= wr_pulse_d;
         bad_op_q   <= bad_op_d;
      end
   end

   always_ff @(posedge clk) begin
      sh_q  <= sh_d;
      ptr_q <= ptr_d;
   end

   // Registered read keeps the array mappable onto block RAM
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[ptr_q] <= sh_in[7:0];
      end
      if (fetch_en) begin
         rd_byte_q <= mem[ptr_d];
      end
   end

   assign sdi_ram  = sdi_q;
   assign busy     = ~css_sync_q[1];
   assign wr_pulse = wr_pulse_q;
   assign bad_op   = bad_op_q;

endmodule

// File: tb/tb_spi_sram_responder.sv
// Bench for spi_sram_responder: a bit-banged SPI master plus a plain byte-array memory
// model; each scenario task compares received bytes and pulse counts against the model.
module tb_spi_sram_responder;

   logic clk = 1'b0;
   logic nrst, sck, css, sdo;
   logic sdi, busy, wr_pulse, bad_op;

   int checks = 0;
   int errors = 0;
   int wr_cnt = 0;
   int bad_cnt = 0;
   int sdi_hi = 0;

   logic [7:0] mdl [0:65535];
   logic [7:0] wbuf_q [$];
   logic [7:0] rd_q [$];

   spi_sram_responder dut (
      .clk      (clk),
      .nrst     (nrst),
      .sck_ram  (sck),
      .css_ram  (css),
      .sdo_ram  (sdo),
      .sdi_ram  (sdi),
      .busy     (busy),
      .wr_pulse (wr_pulse),
      .bad_op   (bad_op)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_pulse) wr_cnt++;
      if (bad_op) bad_cnt++;
      if (sdi) sdi_hi++;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic spi_bit(input logic b, input int half, output logic r);
      sdo = b;
      wait_clk(half);
      sck = 1'b1;
      r = sdi;
      wait_clk(half);
      sck = 1'b0;
   endtask

   task automatic spi_byte(input logic [7:0] tx, input int half, output logic [7:0] rx);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         spi_bit(tx[i], half, r);
         rx[i] = r;
      end
   endtask

   task automatic cs_off(input int half);
      wait_clk(half);
      css = 1'b1;
      wait_clk(8);
   endtask

   task automatic spi_write(input logic [23:0] a, input int half);
      logic [7:0] r;
      logic [15:0] ma;
      css = 1'b0;
      spi_byte(8'h02, half, r);
      spi_byte(a[23:16], half, r);
      spi_byte(a[15:8], half, r);
      spi_byte(a[7:0], half, r);
      for (int i = 0; i < wbuf_q.size(); i++) begin
         spi_byte(wbuf_q[i], half, r);
         ma = a[15:0] + 16'(i);
         mdl[ma] = wbuf_q[i];
      end
      cs_off(half);
   endtask

   task automatic spi_read(input logic [23:0] a, input int n, input int half);
      logic [7:0] r;
      css = 1'b0;
      spi_byte(8'h03, half, r);
      spi_byte(a[23:16], half, r);
      spi_byte(a[15:8], half, r);
      spi_byte(a[7:0], half, r);
      rd_q.delete();
      for (int i = 0; i < n; i++) begin
         spi_byte(8'h00, half, r);
         rd_q.push_back(r);
      end
      cs_off(half);
   endtask

   task automatic test_reset();
      nrst = 1'b1;
      wait_clk(1);
      nrst = 1'b0;
      wait_clk(3);
      checks++; if (sdi !== 1'b0) begin errors++; $display("FAIL reset_sdi: got %b expected 0", sdi); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (wr_pulse !== 1'b0) begin errors++; $display("FAIL reset_wr_pulse: got %b expected 0", wr_pulse); end
      checks++; if (bad_op !== 1'b0) begin errors++; $display("FAIL reset_bad_op: got %b expected 0", bad_op); end
      nrst = 1'b1;
      wait_clk(6);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
   endtask

   task automatic test_write_read();
      int w0;
      css = 1'b0;
      wait_clk(5);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_selected: got %b expected 1", busy); end
      css = 1'b1;
      wait_clk(5);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_deselected: got %b expected 0", busy); end
      w0 = wr_cnt;
      wbuf_q = '{8'hA5};
      spi_write(24'h000010, 5);
      checks++; if (wr_cnt - w0 != 1) begin errors++; $display("FAIL wr_a5_pulses: got %0d expected 1", wr_cnt - w0); end
      spi_read(24'h000010, 1, 5);
      checks++; if (rd_q[0] !== 8'hA5) begin errors++; $display("FAIL read_a5: got %h expected a5", rd_q[0]); end
   endtask

   task automatic test_wrap();
      int w0;
      logic [15:0] ma;
      w0 = wr_cnt;
      wbuf_q = '{8'h11, 8'h22, 8'h33};
      spi_write(24'h00FFFE, 5);
      checks++; if (wr_cnt - w0 != 3) begin errors++; $display("FAIL wrap_pulses: got %0d expected 3", wr_cnt - w0); end
      spi_read(24'h00FFFE, 3, 5);
      for (int i = 0; i < 3; i++) begin
         ma = 16'hFFFE + 16'(i);
         checks++;
         if (rd_q[i] !== mdl[ma]) begin
            errors++; $display("FAIL wrap_read[%0d]: got %h expected %h", i, rd_q[i], mdl[ma]);
         end
      end
      spi_read(24'h000000, 1, 5);
      checks++; if (rd_q[0] !== 8'h33) begin errors++; $display("FAIL wrap_addr0: got %h expected 33", rd_q[0]); end
   endtask

   task automatic test_bad_op();
      int w0, b0, s0;
      logic [7:0] r;
      w0 = wr_cnt; b0 = bad_cnt; s0 = sdi_hi;
      css = 1'b0;
      spi_byte(8'h9F, 5, r);
      for (int i = 0; i < 3; i++) spi_byte(8'($urandom), 5, r);
      cs_off(5);
      checks++; if (bad_cnt - b0 != 1) begin errors++; $display("FAIL bad_op_pulses: got %0d expected 1", bad_cnt - b0); end
      checks++; if (wr_cnt - w0 != 0) begin errors++; $display("FAIL bad_op_writes: got %0d expected 0", wr_cnt - w0); end
      checks++; if (sdi_hi - s0 != 0) begin errors++; $display("FAIL bad_op_sdi: got %0d high cycles expected 0", sdi_hi - s0); end
      spi_read(24'h000000, 1, 5);
      checks++; if (rd_q[0] !== mdl[0]) begin errors++; $display("FAIL bad_op_keep: got %h expected %h", rd_q[0], mdl[0]); end
   endtask

   task automatic test_partial_write();
      int w0;
      logic [7:0] r;
      logic rb;
      wbuf_q = '{8'($urandom)};
      spi_write(24'h000021, 5);
      w0 = wr_cnt;
      css = 1'b0;
      spi_byte(8'h02, 5, r);
      spi_byte(8'h00, 5, r);
      spi_byte(8'h00, 5, r);
      spi_byte(8'h20, 5, r);
      spi_byte(8'hC3, 5, r);
      for (int i = 0; i < 5; i++) spi_bit(1'($urandom), 5, rb);
      cs_off(5);
      mdl[16'h0020] = 8'hC3;
      checks++; if (wr_cnt - w0 != 1) begin errors++; $display("FAIL partial_pulses: got %0d expected 1", wr_cnt - w0); end
      spi_read(24'h000020, 2, 5);
      checks++; if (rd_q[0] !== 8'hC3) begin errors++; $display("FAIL partial_0x20: got %h expected c3", rd_q[0]); end
      checks++; if (rd_q[1] !== mdl[16'h0021]) begin errors++; $display("FAIL partial_0x21: got %h expected %h", rd_q[1], mdl[16'h0021]); end
   endtask

   task automatic test_simul_edge();
      logic [7:0] r, d;
      logic [15:0] a;
      logic rb;
      int w0;
      a = 16'($urandom);
      d = 8'($urandom);
      w0 = wr_cnt;
      sdo = 1'b0;
      css = 1'b0;
      sck = 1'b1;
      wait_clk(5);
      sck = 1'b0;
      for (int i = 6; i >= 0; i--) spi_bit(i == 1, 5, rb);
      spi_byte(8'h00, 5, r);
      spi_byte(a[15:8], 5, r);
      spi_byte(a[7:0], 5, r);
      spi_byte(d, 5, r);
      cs_off(5);
      mdl[a] = d;
      checks++; if (wr_cnt - w0 != 1) begin errors++; $display("FAIL simul_pulses: got %0d expected 1", wr_cnt - w0); end
      spi_read({8'h00, a}, 1, 5);
      checks++; if (rd_q[0] !== d) begin errors++; $display("FAIL simul_read: got %h expected %h", rd_q[0], d); end
   endtask

   task automatic test_reset_midread();
      logic [7:0] r;
      logic rb;
      wbuf_q = '{8'hFF};
      spi_write(24'h000040, 5);
      css = 1'b0;
      spi_byte(8'h03, 5, r);
      spi_byte(8'h00, 5, r);
      spi_byte(8'h00, 5, r);
      spi_byte(8'h40, 5, r);
      for (int i = 0; i < 3; i++) spi_bit(1'b0, 5, rb);
      wait_clk(5);
      checks++; if (sdi !== 1'b1) begin errors++; $display("FAIL midread_sdi: got %b expected 1", sdi); end
      nrst = 1'b0;
      #1;
      checks++; if (sdi !== 1'b0) begin errors++; $display("FAIL rst_sdi: got %b expected 0", sdi); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
      wait_clk(3);
      nrst = 1'b1;
      wait_clk(4);
      css = 1'b1;
      wait_clk(8);
      spi_read(24'h000040, 1, 5);
      checks++; if (rd_q[0] !== 8'hFF) begin errors++; $display("FAIL rst_reread: got %h expected ff", rd_q[0]); end
   endtask

   task automatic test_random();
      int w0, n, hw, hr;
      logic [15:0] a, ma;
      for (int it = 0; it < 6; it++) begin
         n  = $urandom_range(1, 4);
         hw = $urandom_range(4, 6);
         hr = $urandom_range(4, 6);
         a  = 16'($urandom);
         wbuf_q.delete();
         for (int i = 0; i < n; i++) wbuf_q.push_back(8'($urandom));
         w0 = wr_cnt;
         spi_write({8'($urandom), a}, hw);
         checks++; if (wr_cnt - w0 != n) begin errors++; $display("FAIL rand_pulses[%0d]: got %0d expected %0d", it, wr_cnt - w0, n); end
         spi_read({8'($urandom), a}, n, hr);
         for (int i = 0; i < n; i++) begin
            ma = a + 16'(i);
            checks++;
            if (rd_q[i] !== mdl[ma]) begin
               errors++; $display("FAIL rand_read[%0d][%0d]: got %h expected %h", it, i, rd_q[i], mdl[ma]);
            end
         end
      end
   endtask

   task automatic test_min_timing();
      logic [15:0] a, ma;
      a = 16'($urandom);
      wbuf_q.delete();
      for (int i = 0; i < 4; i++) wbuf_q.push_back(8'($urandom));
      spi_write({8'h00, a}, 4);
      spi_read({8'h00, a}, 4, 4);
      for (int i = 0; i < 4; i++) begin
         ma = a + 16'(i);
         checks++;
         if (rd_q[i] !== mdl[ma]) begin
            errors++; $display("FAIL min_timing[%0d]: got %h expected %h", i, rd_q[i], mdl[ma]);
         end
      end
   endtask

   initial begin
      sck = 1'b0;
      css = 1'b1;
      sdo = 1'b0;
      nrst = 1'b1;
      test_reset();
      test_write_read();
      test_wrap();
      test_bad_op();
      test_partial_write();
      test_simul_edge();
      test_reset_midread();
      test_random();
      test_min_timing();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
